// File: rtl/fns_dec_seq.sv
// Serial Fibonacci-numeral-system decoder: one codeword bit per cycle,
// weights generated on the fly, early exit after the highest set bit.
module fns_dec_seq #(
  parameter int N  = 20,
  parameter int DW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  codein,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dataout,
  output logic          ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_shift;
  logic [DW:0]   r_acc;
  logic [DW:0]   r_cur;
  logic [DW:0]   r_nxt;

  // Bit DW of a weight is a sticky ">= 2^DW" flag over a modulo-2^DW
  // value, so a saturated weight is recognisable yet the sum stays exact.
  logic [DW:0]   w_add;
  logic [DW:0]   w_wadd;
  logic [DW:0]   w_nxt;
  logic          w_last;

  assign w_add  = {1'b0, r_acc[DW-1:0]} + {1'b0, r_cur[DW-1:0]};
  assign w_wadd = {1'b0, r_cur[DW-1:0]} + {1'b0, r_nxt[DW-1:0]};
  assign w_nxt  = {r_cur[DW] | r_nxt[DW] | w_wadd[DW], w_wadd[DW-1:0]};
  assign w_last = (r_shift[N-1:1] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_acc   <= '0;
      r_cur   <= '0;
      r_nxt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift <= codein;
            r_acc   <= '0;
            r_cur   <= {{DW{1'b0}}, 1'b1};
            r_nxt   <= {{DW{1'b0}}, 1'b1};
            r_state <= (codein == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // Top acc bit is the sticky overflow for this word
          if (r_shift[0])
            r_acc <= {r_acc[DW] | w_add[DW] | r_cur[DW],
                      w_add[DW-1:0]};
          r_shift <= r_shift >> 1;
          r_cur   <= r_nxt;
          r_nxt   <= w_nxt;
          if (w_last)
            r_state <= DONE;
        end
        DONE: begin
          if (out_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign dataout   = r_acc[DW-1:0];
  assign ovf       = r_acc[DW];

endmodule

// File: tb/tb_fns_dec_seq.sv
// Bench for fns_dec_seq: DW=15 and DW=12 instances share stimulus;
// expected results queued at accept, compared when out_valid appears.
module tb_fns_dec_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [19:0] codein = '0;

  logic        in_ready, out_valid, ovf, busy;
  logic [14:0] dataout;
  logic        in_ready12, out_valid12, ovf12, busy12;
  logic [11:0] dataout12;

  fns_dec_seq #(.N(20), .DW(15)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .codein(codein),
    .out_valid(out_valid), .out_ready(out_ready),
    .dataout(dataout), .ovf(ovf), .busy(busy)
  );

  fns_dec_seq #(.N(20), .DW(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready12),
    .codein(codein),
    .out_valid(out_valid12), .out_ready(out_ready),
    .dataout(dataout12), .ovf(ovf12), .busy(busy12)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] d15;
    logic        o15;
    logic [11:0] d12;
    logic        o12;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  logic [14:0] g_d15;
  logic        g_o15;
  logic [11:0] g_d12;
  logic        g_o12;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [63:0] fsum(input logic [19:0] c);
    logic [63:0] a, b, t, s;
    a = 1; b = 1; s = 0;
    for (int k = 0; k < 20; k++) begin
      if (c[k]) s = s + a;
      t = a + b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  function automatic int hib(input logic [19:0] c);
    int h;
    h = -1;
    for (int k = 0; k < 20; k++)
      if (c[k]) h = k;
    return h;
  endfunction

  task automatic send(input logic [19:0] c, input int pre,
                      input int hold);
    exp_t e;
    logic [63:0] s;
    int lat;
    s = fsum(c);
    e.d15 = s[14:0];
    e.o15 = (s > 64'd32767);
    e.d12 = s[11:0];
    e.o12 = (s > 64'd4095);
    e.lat = (c == 0) ? 0 : hib(c) + 1;
    repeat (pre) begin
      in_valid = 1'b0;
      codein = 20'($urandom);
      @(negedge clk);
    end
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    codein = c;
    sb.push_back(e);
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom);
      codein = 20'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("valid12", out_valid12, 1);
    chk("busy_done", busy, 1);
    chk("ready_done", in_ready, 0);
    chk("data15", dataout, e.d15);
    chk("ovf15", ovf, e.o15);
    chk("data12", dataout12, e.d12);
    chk("ovf12", ovf12, e.o12);
    g_d15 = dataout; g_o15 = ovf;
    g_d12 = dataout12; g_o12 = ovf12;
    repeat (hold) begin
      out_ready = 1'b0;
      in_valid = 1'($urandom);
      codein = 20'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", dataout, e.d15);
      chk("hold_ovf", ovf, e.o15);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    codein = 20'($urandom);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("back_idle", in_ready, 1);
    chk("valid_low", out_valid, 0);
    chk("busy_low", busy, 0);
  endtask

  initial begin
    logic [19:0] mask, c;
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", dataout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(20'h00001, 0, 0);
    chk("one_data", g_d15, 1);
    chk("one_ovf", g_o15, 0);
    send(20'hFFFFF, 0, 0);
    chk("all_data", g_d15, 17710);
    chk("all_ovf", g_o15, 0);
    chk("all_d12", g_d12, 1326);
    chk("all_o12", g_o12, 1);
    send(20'h80000, 1, 1);
    chk("top_data", g_d15, 6765);
    send(20'h00000, 0, 0);
    chk("zero_data", g_d15, 0);
    send(20'h12345, 0, 5);

    in_valid = 1'b1;
    codein = 20'hFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", in_ready, 1);
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", dataout, 0);
    chk("arst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(20'h00005, 0, 0);
    chk("five_data", g_d15, 3);

    for (int i = 0; i < 1200; i++) begin
      mask = 20'hFFFFF >> $urandom_range(0, 19);
      c = 20'($urandom) & mask;
      send(c, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
